kbd_text_term: RTL and testbench
================================

Name: kbd_text_term

Overview:
Parametrised keyboard-to-text-screen controller. Consumes PS/2 set-2 scan bytes from the ps2_keyboard FIFO and decodes make/break/shift/extended prefixes. Writes ASCII into the character RAM that the VGA text path reads, maintaining a cursor and a circular scroll base. Adds backspace, enter, line clearing, power-up screen clear and scrolling, all of which the first-generation keyboard/VGA glue lacked.

Parameters:
COLS, 80, characters per row (1..128)
ROWS, 60, text rows (1..64)
COL_W, 7, cursor column width, ceil(log2(COLS))
ROW_W, 6, cursor row width, ceil(log2(ROWS))
CHAR_W, 7, character code width

Ports:
clk  in  1  system clock; all logic on posedge
clrn  in  1  asynchronous active-low reset
kbd_ready  in  1  FIFO non-empty; kbd_data valid
kbd_data  in  8  scan byte at FIFO head
kbd_overflow  in  1  FIFO overflow flag
kbd_rdn  out  1  active-low pop strobe, one clk wide
cram_we  out  1  char RAM write enable
cram_addr  out  ROW_W+COL_W  {row,col} write address
cram_wdata  out  CHAR_W  character written
cursor_row  out  ROW_W  current cursor row
cursor_col  out  COL_W  current cursor column
top_row  out  ROW_W  physical row shown at screen top; display adds it mod ROWS
busy  out  1  high in INIT/CLEAR; keyboard not serviced
caps_led  out  1  caps-lock state

Behaviour:
- Reset is clk-independent: kbd_rdn=1, cram_we=0, cursor 0/0, top_row=0, shift/brk/ext/full/caps=0, state=INIT, busy=1.
- INIT: write 0x20 to every {row,col}, row-major, one per clk (ROWS*COLS cycles), then go to IDLE with busy=0. Reset during INIT or CLEAR restarts INIT from 0/0.
- IDLE: if kbd_ready, go to POP: capture kbd_data and drive kbd_rdn=0 for exactly one clk. Next go to DECODE. At most one pop per 3 clks.
- DECODE:
  - 0xF0 sets brk. 0xE0 sets ext. Either returns to IDLE.
  - Any other byte with brk=1: release. 0x12 clears shift_l; 0x59 clears shift_r. No write. Clear brk/ext.
  - With ext=1 and no brk: ignored; clear ext.
  - Make 0x12/0x59 sets shift_l/shift_r. 0x66 is backspace. 0x5A is enter. A mapped printable byte goes to WRITE. An unmapped byte is ignored.
- shift = shift_l | shift_r. Letters are uppercase when shift XOR caps. Digits and punctuation follow shift only.
- WRITE: one clk cram_we=1 at {cursor_row,cursor_col}. If col==COLS-1, perform NEWLINE; else col+1.
- Backspace: if col>0, col-1 and write 0x20 at the new col. At col==0 it is a no-op (no cross-row backspace).
- NEWLINE (enter or wrap):
  - col=0; row=(row==ROWS-1)?0:row+1.
  - A wrap from ROWS-1 sets full.
  - If full, top_row=(new row+1) mod ROWS.
  - Then CLEAR: write 0x20 to cols 0..COLS-1 of the new row, COLS clks, busy=1, then IDLE.
- kbd_overflow=1 sampled in IDLE clears brk/ext (resync); bytes already queued are still consumed.
- cram_we is high only in INIT, WRITE, backspace and CLEAR cycles; cram_addr and cram_wdata are valid whenever cram_we=1.

Optional Feature:
KBD_TERM_CAPS_EN: when defined, make 0x58 toggles caps and caps_led=caps. Break 0x58 is ignored. When undefined, 0x58 is treated as unmapped, caps is held at 0 and caps_led=0.

Decomposition:
- Package kbd_term_pkg holds:
  - scan-code constants: SC_BREAK=0xF0, SC_EXT=0xE0, SC_LSHIFT=0x12, SC_RSHIFT=0x59, SC_CAPS=0x58, SC_BKSP=0x66, SC_ENTER=0x5A, SC_SPACE=0x29;
  - ASCII_SPACE=0x20;
  - the state enum {INIT,IDLE,POP,DECODE,WRITE,CLEAR}.
- One combinational sub-module, kbd_scan2ascii, takes scan, shift and caps and returns valid and ascii. It covers set-2 letters, digits, space and basic punctuation.

Test Plan:
- Release reset, run ROWS*COLS clks -> 4800 writes of 0x20 with default parameters; busy falls; cursor 0/0.
- FIFO bytes 1C, F0 1C -> single write 0x61 at addr {0,0}; cursor_col=1; break produces no write.
- Bytes 12 1C F0 12 1C -> writes 0x41 then 0x61; shift cleared after F0 12.
- 80 printable makes at row 0 -> 80th written at col 79, cursor 1/0, then 80 writes of 0x20 on row 1 with busy=1.
- Cursor col 3, byte 66 -> write 0x20 at col 2, col=2; at col 0, 66 -> no write.
- 60 enters -> row wraps to 0, top_row=1. Assert clrn mid-CLEAR -> outputs reset and INIT restarts.

Source files
------------

// File: rtl/kbd_term_pkg.sv
// kbd_term_pkg: shared constants and types for the keyboard text terminal.
//   - PS/2 set-2 scan codes the decoder recognises specially
//   - ASCII blank used for screen clearing and backspace
//   - controller state encoding
package kbd_term_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    POP,
    DECODE,
    WRITE,
    CLEAR
  } state_e;

endpackage

// File: rtl/kbd_scan2ascii.sv
// kbd_scan2ascii: combinational PS/2 set-2 make code to ASCII translation.
// Covers letters, digits, space and the basic US punctuation keys.
// Ports:
//   scan_i   - make code (prefixes already stripped)
//   shift_i  - either shift key held
//   caps_i   - caps-lock state
//   valid_o  - scan_i is a printable key
//   ascii_o  - character for scan_i under the current modifiers
module kbd_scan2ascii
  import kbd_term_pkg::*;
#(
  parameter int CHAR_W = 7
) (
  input  logic [7:0]        scan_i,
  input  logic              shift_i,
  input  logic              caps_i,
  output logic              valid_o,
  output logic [CHAR_W-1:0] ascii_o
);

  logic [7:0] lo;
  logic [7:0] hi;
  logic       letter;
  logic       upper;

  always_comb begin
    {lo, hi} = 16'h0000;
    case (scan_i)
      8'h1C: {lo, hi} = {"a", "A"};
      8'h32: {lo, hi} = {"b", "B"};
      8'h21: {lo, hi} = {"c", "C"};
      8'h23: {lo, hi} = {"d", "D"};
      8'h24: {lo, hi} = {"e", "E"};
      8'h2B: {lo, hi} = {"f", "F"};
      8'h34: {lo, hi} = {"g", "G"};
      8'h33: {lo, hi} = {"h", "H"};
      8'h43: {lo, hi} = {"i", "I"};
      8'h3B: {lo, hi} = {"j", "J"};
      8'h42: {lo, hi} = {"k", "K"};
      8'h4B: {lo, hi} = {"l", "L"};
      8'h3A: {lo, hi} = {"m", "M"};
      8'h31: {lo, hi} = {"n", "N"};
      8'h44: {lo, hi} = {"o", "O"};
      8'h4D: {lo, hi} = {"p", "P"};
      8'h15: {lo, hi} = {"q", "Q"};
      8'h2D: {lo, hi} = {"r", "R"};
      8'h1B: {lo, hi} = {"s", "S"};
      8'h2C: {lo, hi} = {"t", "T"};
      8'h3C: {lo, hi} = {"u", "U"};
      8'h2A: {lo, hi} = {"v", "V"};
      8'h1D: {lo, hi} = {"w", "W"};
      8'h22: {lo, hi} = {"x", "X"};
      8'h35: {lo, hi} = {"y", "Y"};
      8'h1A: {lo, hi} = {"z", "Z"};
      8'h16: {lo, hi} = {"1", "!"};
      8'h1E: {lo, hi} = {"2", "@"};
      8'h26: {lo, hi} = {"3", "#"};
      8'h25: {lo, hi} = {"4", "$"};
      8'h2E: {lo, hi} = {"5", "%"};
      8'h36: {lo, hi} = {"6", "^"};
      8'h3D: {lo, hi} = {"7", "&"};
      8'h3E: {lo, hi} = {"8", "*"};
      8'h46: {lo, hi} = {"9", "("};
      8'h45: {lo, hi} = {"0", ")"};
      8'h0E: {lo, hi} = {8'h60, "~"};
      8'h4E: {lo, hi} = {"-", "_"};
      8'h55: {lo, hi} = {"=", "+"};
      8'h54: {lo, hi} = {"[", "{"};
      8'h5B: {lo, hi} = {"]", "}"};
      8'h5D: {lo, hi} = {"\\", "|"};
      8'h4C: {lo, hi} = {";", ":"};
      8'h52: {lo, hi} = {"'", "\""};
      8'h41: {lo, hi} = {",", "<"};
      8'h49: {lo, hi} = {".", ">"};
      8'h4A: {lo, hi} = {"/", "?"};
      SC_SPACE: {lo, hi} = {" ", " "};
      default: {lo, hi} = 16'h0000;
    endcase
    // caps-lock only affects letters; everything else follows shift alone
    letter  = (lo >= 8'h61) && (lo <= 8'h7A);
    upper   = letter ? (shift_i ^ caps_i) : shift_i;
    valid_o = (lo != 8'h00);
    ascii_o = CHAR_W'(upper ? hi : lo);
  end

endmodule

// File: rtl/kbd_text_term.sv
// kbd_text_term: keyboard-to-text-screen controller.
// Pops PS/2 set-2 bytes from the keyboard FIFO, tracks break/extended
// prefixes and modifiers, and writes ASCII into the character RAM with a
// cursor, backspace, enter, per-line clearing and a circular scroll base.
// Optional build macro: KBD_TERM_CAPS_EN enables the caps-lock key/LED.
// Ports:
//   clk, clrn                 - clock, async active-low reset
//   kbd_ready/data/overflow   - FIFO status, head byte, overflow flag
//   kbd_rdn                   - active-low pop strobe (one clk)
//   cram_we/addr/wdata        - character RAM write port, addr = {row,col}
//   cursor_row/cursor_col     - cursor position
//   top_row                   - physical row displayed at screen top
//   busy                      - screen initialise or line clear in progress
//   caps_led                  - caps-lock state
module kbd_text_term
  import kbd_term_pkg::*;
#(
  parameter int COLS   = 80,
  parameter int ROWS   = 60,
  parameter int COL_W  = 7,
  parameter int ROW_W  = 6,
  parameter int CHAR_W = 7
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   kbd_ready,
  input  logic [7:0]             kbd_data,
  input  logic                   kbd_overflow,
  output logic                   kbd_rdn,
  output logic                   cram_we,
  output logic [ROW_W+COL_W-1:0] cram_addr,
  output logic [CHAR_W-1:0]      cram_wdata,
  output logic [ROW_W-1:0]       cursor_row,
  output logic [COL_W-1:0]       cursor_col,
  output logic [ROW_W-1:0]       top_row,
  output logic                   busy,
  output logic                   caps_led
);

  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [CHAR_W-1:0] BLANK    = CHAR_W'(ASCII_SPACE);

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  cursor_row_q, cursor_row_d;
  logic [COL_W-1:0]  cursor_col_q, cursor_col_d;
  logic [ROW_W-1:0]  top_row_q, top_row_d;
  logic [ROW_W-1:0]  clr_row_q, clr_row_d;
  logic [COL_W-1:0]  clr_col_q, clr_col_d;
  logic [7:0]        scan_q, scan_d;
  logic [CHAR_W-1:0] char_q, char_d;
  logic              shift_l_q, shift_l_d;
  logic              shift_r_q, shift_r_d;
  logic              brk_q, brk_d;
  logic              ext_q, ext_d;
  logic              full_q, full_d;
  logic              caps_q, caps_d;
  // Holds off the first INIT write for one clk so nothing is written while
  // reset is asserted.
  logic              init_arm_q;

  logic              map_valid;
  logic [CHAR_W-1:0] map_ascii;
  logic [ROW_W-1:0]  nl_row;
  logic [ROW_W-1:0]  nl_top;
  logic              nl_full;
  logic              do_nl;

  kbd_scan2ascii #(.CHAR_W(CHAR_W)) u_map (
    .scan_i  (scan_q),
    .shift_i (shift_l_q | shift_r_q),
    .caps_i  (caps_q),
    .valid_o (map_valid),
    .ascii_o (map_ascii)
  );

  // Newline targets: next row with wrap; once the screen has wrapped the
  // display top tracks one row past the cursor.
  always_comb begin
    nl_row  = (cursor_row_q == LAST_ROW) ? '0 : cursor_row_q + ROW_W'(1);
    nl_full = full_q | (cursor_row_q == LAST_ROW);
    nl_top  = (nl_row == LAST_ROW) ? '0 : nl_row + ROW_W'(1);
  end

  always_comb begin
    state_d      = state_q;
    cursor_row_d = cursor_row_q;
    cursor_col_d = cursor_col_q;
    top_row_d    = top_row_q;
    clr_row_d    = clr_row_q;
    clr_col_d    = clr_col_q;
    scan_d       = scan_q;
    char_d       = char_q;
    shift_l_d    = shift_l_q;
    shift_r_d    = shift_r_q;
    brk_d        = brk_q;
    ext_d        = ext_q;
    full_d       = full_q;
    caps_d       = caps_q;
    kbd_rdn      = 1'b1;
    cram_we      = 1'b0;
    cram_addr    = {cursor_row_q, cursor_col_q};
    cram_wdata   = BLANK;
    do_nl        = 1'b0;

    case (state_q)
      INIT: begin
        if (init_arm_q) begin
          cram_we   = 1'b1;
          cram_addr = {clr_row_q, clr_col_q};
          if (clr_col_q == LAST_COL) begin
            clr_col_d = '0;
            if (clr_row_q == LAST_ROW) begin
              clr_row_d = '0;
              state_d   = IDLE;
            end else begin
              clr_row_d = clr_row_q + ROW_W'(1);
            end
          end else begin
            clr_col_d = clr_col_q + COL_W'(1);
          end
        end
      end

      IDLE: begin
        if (kbd_overflow) begin
          brk_d = 1'b0;
          ext_d = 1'b0;
        end
        // head byte is stable here; the FIFO advances on the POP edge
        if (kbd_ready) begin
          scan_d  = kbd_data;
          state_d = POP;
        end
      end

      POP: begin
        kbd_rdn = 1'b0;
        state_d = DECODE;
      end

      DECODE: begin
        state_d = IDLE;
        if (scan_q == SC_BREAK) begin
          brk_d = 1'b1;
        end else if (scan_q == SC_EXT) begin
          ext_d = 1'b1;
        end else if (brk_q) begin
          if (scan_q == SC_LSHIFT) shift_l_d = 1'b0;
          if (scan_q == SC_RSHIFT) shift_r_d = 1'b0;
          brk_d = 1'b0;
          ext_d = 1'b0;
        end else if (ext_q) begin
          ext_d = 1'b0;
        end else if (scan_q == SC_LSHIFT) begin
          shift_l_d = 1'b1;
        end else if (scan_q == SC_RSHIFT) begin
          shift_r_d = 1'b1;
        end else if (scan_q == SC_CAPS) begin
`ifdef KBD_TERM_CAPS_EN
          caps_d = ~caps_q;
`endif
        end else if (scan_q == SC_BKSP) begin
          if (cursor_col_q != '0) begin
            cram_we      = 1'b1;
            cram_addr    = {cursor_row_q, cursor_col_q - COL_W'(1)};
            cursor_col_d = cursor_col_q - COL_W'(1);
          end
        end else if (scan_q == SC_ENTER) begin
          do_nl = 1'b1;
        end else if (map_valid) begin
          char_d  = map_ascii;
          state_d = WRITE;
        end
      end

      WRITE: begin
        cram_we    = 1'b1;
        cram_wdata = char_q;
        if (cursor_col_q == LAST_COL) begin
          do_nl = 1'b1;
        end else begin
          cursor_col_d = cursor_col_q + COL_W'(1);
          state_d      = IDLE;
        end
      end

      CLEAR: begin
        cram_we   = 1'b1;
        cram_addr = {cursor_row_q, clr_col_q};
        if (clr_col_q == LAST_COL) begin
          clr_col_d = '0;
          state_d   = IDLE;
        end else begin
          clr_col_d = clr_col_q + COL_W'(1);
        end
      end

      default: state_d = INIT;
    endcase

    if (do_nl) begin
      cursor_row_d = nl_row;
      cursor_col_d = '0;
      full_d       = nl_full;
      if (nl_full) top_row_d = nl_top;
      state_d      = CLEAR;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= INIT;
      cursor_row_q <= '0;
      cursor_col_q <= '0;
      top_row_q    <= '0;
      clr_row_q    <= '0;
      clr_col_q    <= '0;
      scan_q       <= '0;
      char_q       <= '0;
      shift_l_q    <= 1'b0;
      shift_r_q    <= 1'b0;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      full_q       <= 1'b0;
      caps_q       <= 1'b0;
      init_arm_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cursor_row_q <= cursor_row_d;
      cursor_col_q <= cursor_col_d;
      top_row_q    <= top_row_d;
      clr_row_q    <= clr_row_d;
      clr_col_q    <= clr_col_d;
      scan_q       <= scan_d;
      char_q       <= char_d;
      shift_l_q    <= shift_l_d;
      shift_r_q    <= shift_r_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
      full_q       <= full_d;
      caps_q       <= caps_d;
      init_arm_q   <= 1'b1;
    end
  end

  assign cursor_row = cursor_row_q;
  assign cursor_col = cursor_col_q;
  assign top_row    = top_row_q;
  assign busy       = (state_q == INIT) || (state_q == CLEAR);
  assign caps_led   = caps_q;

endmodule

// File: tb/tb_kbd_text_term.sv
// tb_kbd_text_term: directed bench for kbd_text_term with default geometry.
// Scan bytes are fed through a queue-based FIFO model; every expected RAM
// write is queued alongside the stimulus and matched by a write monitor.
module tb_kbd_text_term;

  localparam int COLS = 80;
  localparam int ROWS = 60;
`ifdef KBD_TERM_CAPS_EN
  localparam bit CAPS = 1'b1;
`else
  localparam bit CAPS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        kbd_ready = 1'b0;
  logic [7:0]  kbd_data = 8'h00;
  logic        kbd_overflow = 1'b0;
  logic        kbd_rdn;
  logic        cram_we;
  logic [12:0] cram_addr;
  logic [6:0]  cram_wdata;
  logic [5:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic [5:0]  top_row;
  logic        busy;
  logic        caps_led;

  typedef struct packed {
    logic [12:0] addr;
    logic [6:0]  data;
    logic        busy;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] fifo_q[$];
  int         n_tests = 0;
  int         n_fail = 0;

  kbd_text_term dut (
    .clk          (clk),
    .clrn         (clrn),
    .kbd_ready    (kbd_ready),
    .kbd_data     (kbd_data),
    .kbd_overflow (kbd_overflow),
    .kbd_rdn      (kbd_rdn),
    .cram_we      (cram_we),
    .cram_addr    (cram_addr),
    .cram_wdata   (cram_wdata),
    .cursor_row   (cursor_row),
    .cursor_col   (cursor_col),
    .top_row      (top_row),
    .busy         (busy),
    .caps_led     (caps_led)
  );

  always #5 clk = ~clk;

  // FIFO model: head advances on a pop strobe, flags refreshed each cycle
  always @(negedge clk) begin
    if (!kbd_rdn && fifo_q.size() > 0) void'(fifo_q.pop_front());
    kbd_ready = (fifo_q.size() > 0);
    kbd_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  // write monitor
  always @(negedge clk) begin
    if (clrn && cram_we) begin
      wr_t obs;
      wr_t want;
      obs = {cram_addr, cram_wdata, busy};
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_write: got addr %h data %h busy %b, want no write",
               obs.addr, obs.data, obs.busy);
      end
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        n_tests++;
        assert (obs === want) else begin
          n_fail++;
          $error("FAIL wr: got addr %h data %h busy %b, want addr %h data %h busy %b",
                 obs.addr, obs.data, obs.busy, want.addr, want.data, want.busy);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic exp_wr(input int r, input int c, input logic [7:0] ch, input logic b);
    wr_t w;
    w.addr = {6'(r), 7'(c)};
    w.data = ch[6:0];
    w.busy = b;
    exp_q.push_back(w);
  endtask

  task automatic exp_row_clear(input int r);
    for (int c = 0; c < COLS; c++) exp_wr(r, c, 8'h20, 1'b1);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  // wait for FIFO drained and controller quiet, then require all expected
  // writes to have appeared
  task automatic wait_idle(input string tag, input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 8 && n < budget) begin
      @(negedge clk);
      n++;
      if (fifo_q.size() == 0 && !kbd_ready && !busy && kbd_rdn) quiet++;
      else quiet = 0;
    end
    n_tests++;
    assert (quiet >= 8) else begin
      n_fail++;
      $error("FAIL %s_timeout: got %0d quiet cycles want 8", tag, quiet);
    end
    n_tests++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL %s_pending: got %0d writes outstanding want 0", tag, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdn"}, kbd_rdn, 1);
    check({tag, "_we"}, cram_we, 0);
    check({tag, "_row"}, cursor_row, 0);
    check({tag, "_col"}, cursor_col, 0);
    check({tag, "_top"}, top_row, 0);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_caps"}, caps_led, 0);
  endtask

  task automatic exp_init();
    for (int r = 0; r < ROWS; r++) exp_row_clear(r);
  endtask

  initial begin
    int n;

    // reset and power-up clear
    clrn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    exp_init();
    clrn = 1'b1;
    wait_idle("init", 10000);
    check("init_busy", busy, 0);
    check("init_row", cursor_row, 0);
    check("init_col", cursor_col, 0);

    // make then break of 'a'
    send(8'h1C); send(8'hF0); send(8'h1C);
    exp_wr(0, 0, "a", 1'b0);
    wait_idle("a_make_break", 200);
    check("a_col", cursor_col, 1);

    // shifted and unshifted letter
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
    exp_wr(0, 1, "A", 1'b0);
    exp_wr(0, 2, "a", 1'b0);
    wait_idle("shift", 200);
    check("shift_col", cursor_col, 3);

    // backspace down to column 0, then one more that must do nothing
    send(8'h66);
    exp_wr(0, 2, 8'h20, 1'b0);
    wait_idle("bksp1", 200);
    check("bksp1_col", cursor_col, 2);
    send(8'h66); send(8'h66); send(8'h66);
    exp_wr(0, 1, 8'h20, 1'b0);
    exp_wr(0, 0, 8'h20, 1'b0);
    wait_idle("bksp0", 200);
    check("bksp0_col", cursor_col, 0);
    check("bksp0_row", cursor_row, 0);

    // fill row 0, wrap to row 1 which is then cleared
    for (int i = 0; i < COLS; i++) begin
      send(8'h32);
      exp_wr(0, i, "b", 1'b0);
    end
    exp_row_clear(1);
    wait_idle("wrap", 2000);
    check("wrap_row", cursor_row, 1);
    check("wrap_col", cursor_col, 0);
    check("wrap_top", top_row, 0);

    // digits/punctuation, caps key, extended make
    send(8'h16);
    exp_wr(1, 0, "1", 1'b0);
    send(8'h12); send(8'h16); send(8'hF0); send(8'h12);
    exp_wr(1, 1, "!", 1'b0);
    send(8'h4E);
    exp_wr(1, 2, "-", 1'b0);
    send(8'h58); send(8'hF0); send(8'h58);
    wait_idle("caps_on", 200);
    check("caps_led_on", caps_led, CAPS);
    send(8'h1C);
    exp_wr(1, 3, CAPS ? "A" : "a", 1'b0);
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h12);
    exp_wr(1, 4, CAPS ? "a" : "A", 1'b0);
    send(8'h16);
    exp_wr(1, 5, "1", 1'b0);
    send(8'h58); send(8'hF0); send(8'h58);
    send(8'hE0); send(8'h1C);
    send(8'h1C);
    exp_wr(1, 6, "a", 1'b0);
    wait_idle("punct", 400);
    check("caps_led_off", caps_led, 0);
    check("punct_col", cursor_col, 7);

    // dangling break prefix discarded by FIFO overflow
    send(8'hF0);
    wait_idle("ovf_pre", 200);
    kbd_overflow = 1'b1;
    repeat (3) @(negedge clk);
    kbd_overflow = 1'b0;
    send(8'h1C);
    exp_wr(1, 7, "a", 1'b0);
    wait_idle("ovf", 200);
    check("ovf_col", cursor_col, 8);

    // enters down to the last row, then wrap and scroll
    for (int k = 0; k < ROWS - 2; k++) begin
      send(8'h5A);
      exp_row_clear(k + 2);
    end
    wait_idle("enters", 20000);
    check("last_row", cursor_row, ROWS - 1);
    check("last_col", cursor_col, 0);
    check("last_top", top_row, 0);
    send(8'h5A);
    exp_row_clear(0);
    wait_idle("row_wrap", 500);
    check("row_wrap_row", cursor_row, 0);
    check("row_wrap_top", top_row, 1);
    send(8'h5A);
    exp_row_clear(1);
    wait_idle("scroll", 500);
    check("scroll_row", cursor_row, 1);
    check("scroll_top", top_row, 2);

    // reset in the middle of a line clear
    send(8'h5A);
    exp_row_clear(2);
    n = 0;
    while (!(busy && cram_we) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("clear_busy", busy, 1);
    check("clear_row", cursor_row, 2);
    check("clear_top", top_row, 3);
    repeat (10) @(negedge clk);
    clrn = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    exp_init();
    clrn = 1'b1;
    wait_idle("reinit", 10000);
    check("reinit_row", cursor_row, 0);
    check("reinit_col", cursor_col, 0);
    check("reinit_top", top_row, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
